// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX (and later RX) datapaths.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered status flags and show-ahead read data.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop;

  always_comb begin
    push     = wr_en && !full_q;
    pop      = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = (count_d == FULL_CNT);
    empty_d = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_e     PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          tx_enable,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full, fifo_empty, pop;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_valid),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign wr_ready = !fifo_full;

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 avail_q, avail_d;
  logic                 bit_end;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    avail_d = !fifo_empty;
    bit_end = (baud_q == DIV_LAST);
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      // Idle start uses the registered non-empty flag, so a fresh word waits one extra clock.
      ST_IDLE: begin
        baud_d = '0;
        if (avail_q && !fifo_empty && tx_enable) pop = 1'b1;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            if (!fifo_empty && tx_enable) pop = 1'b1;
            else                          state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      state_d = ST_START;
      shift_d = fifo_rd_data;
      par_d   = (^fifo_rd_data) ^ (PARITY == PARITY_ODD);
      bit_d   = '0;
      baud_d  = '0;
    end

    // Line level follows the next state so tx changes exactly on the state edge.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      avail_q <= avail_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
